// File: rtl/decode_issue_stage_if.sv
// Decode/issue stage bus bundle.
// Groups the decode-side handshake and operand inputs, the forwarding
// sources, the execute-side handshake with its registered payload, and the
// hazard-stall counter.
//   slave  : view used by decode_issue_stage (consumes id_*/fwd_*, drives ex_*)
//   master : view used by the surrounding pipeline / testbench
interface decode_issue_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NSRC  = 3,
    parameter int unsigned CW_W  = 28,
    parameter int unsigned CNT_W = 16
) ();
    logic                   flush;

    // Decode side
    logic                   id_valid;
    logic                   id_ready;
    logic [4:0]             id_rs1;
    logic [4:0]             id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic [XLEN-1:0]        id_rs1_val;
    logic [XLEN-1:0]        id_rs2_val;
    logic [CW_W-1:0]        id_cw;
    logic [XLEN-1:0]        id_imm;
    logic [XLEN-1:0]        id_pc;

    // Forwarding sources, index 0 youngest
    logic [NSRC-1:0]        fwd_we;
    logic [NSRC-1:0]        fwd_pend;
    logic [5*NSRC-1:0]      fwd_rd;
    logic [XLEN*NSRC-1:0]   fwd_data;

    // Execute side
    logic                   ex_valid;
    logic                   ex_ready;
    logic [XLEN-1:0]        ex_rs1_val;
    logic [XLEN-1:0]        ex_rs2_val;
    logic [XLEN-1:0]        ex_imm;
    logic [XLEN-1:0]        ex_pc;
    logic [CW_W-1:0]        ex_cw;

    logic [CNT_W-1:0]       stall_cnt;

    modport slave (
        input  flush,
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rs1_val, id_rs2_val, id_cw, id_imm, id_pc,
        input  fwd_we, fwd_pend, fwd_rd, fwd_data,
        input  ex_ready,
        output id_ready,
        output ex_valid, ex_rs1_val, ex_rs2_val, ex_imm, ex_pc, ex_cw,
        output stall_cnt
    );

    modport master (
        output flush,
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rs1_val, id_rs2_val, id_cw, id_imm, id_pc,
        output fwd_we, fwd_pend, fwd_rd, fwd_data,
        output ex_ready,
        input  id_ready,
        input  ex_valid, ex_rs1_val, ex_rs2_val, ex_imm, ex_pc, ex_cw,
        input  stall_cnt
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue pipeline stage with operand forwarding and RAW hazard stall.
// Resolves both source operands against NSRC forwarding sources (youngest
// wins), stalls on unresolvable hazards, and holds one instruction in a
// valid/ready output register towards execute.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : decode_issue_stage_if.slave
//           flush, id_* handshake/operands, fwd_* sources,
//           ex_* handshake/registered payload, stall_cnt
module decode_issue_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NSRC   = 3,
    parameter int unsigned CW_W   = 28,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    decode_issue_stage_if.slave     bus
);

    localparam int unsigned RW = 5;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]    rs2_val_q, rs2_val_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]    match1_c, match2_c;
    logic               hit1_c, hit2_c;
    logic               pend1_c, pend2_c;
    logic [XLEN-1:0]    fwd1_c, fwd2_c;
    logic [XLEN-1:0]    op1_c, op2_c;
    logic               hazard_c;
    logic               ex_valid_c;
    logic               id_ready_c;
    logic               load_c;

    // Per-source RAW match; register 0 is hardwired and never matches
    always_comb begin : match_p
        match1_c = '0;
        match2_c = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            match1_c[i] = bus.fwd_we[i] && bus.id_use_rs1
                          && (bus.fwd_rd[i*RW +: RW] != '0)
                          && (bus.fwd_rd[i*RW +: RW] == bus.id_rs1);
            match2_c[i] = bus.fwd_we[i] && bus.id_use_rs2
                          && (bus.fwd_rd[i*RW +: RW] != '0)
                          && (bus.fwd_rd[i*RW +: RW] == bus.id_rs2);
        end
    end

    // Priority select: first match scanning from youngest source wins
    always_comb begin : select_p
        hit1_c  = 1'b0;
        pend1_c = 1'b0;
        fwd1_c  = '0;
        hit2_c  = 1'b0;
        pend2_c = 1'b0;
        fwd2_c  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (match1_c[i] && !hit1_c) begin
                hit1_c  = 1'b1;
                pend1_c = bus.fwd_pend[i];
                fwd1_c  = bus.fwd_data[i*XLEN +: XLEN];
            end
            if (match2_c[i] && !hit2_c) begin
                hit2_c  = 1'b1;
                pend2_c = bus.fwd_pend[i];
                fwd2_c  = bus.fwd_data[i*XLEN +: XLEN];
            end
        end
    end

    // Hazard and operand mux; without bypass every match stalls so raw data is safe
    always_comb begin : operand_p
        hazard_c = 1'b0;
        op1_c    = bus.id_rs1_val;
        op2_c    = bus.id_rs2_val;
        if (FWD_EN != 0) begin
            hazard_c = (hit1_c && pend1_c) || (hit2_c && pend2_c);
            if (hit1_c) op1_c = fwd1_c;
            if (hit2_c) op2_c = fwd2_c;
        end else begin
            hazard_c = (|match1_c) || (|match2_c);
        end
    end

    assign ex_valid_c = (state_q == S_FULL);
    assign id_ready_c = !bus.flush && !hazard_c && (!ex_valid_c || bus.ex_ready);
    assign load_c     = bus.id_valid && id_ready_c;

    // Output register occupancy and payload capture
    always_comb begin : fsm_p
        state_d   = state_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        cw_d      = cw_q;

        case (state_q)
            S_EMPTY: begin
                if (load_c) state_d = S_FULL;
            end
            S_FULL: begin
                // flush forces id_ready low, so it can never coincide with a load
                if (bus.flush)          state_d = S_EMPTY;
                else if (load_c)        state_d = S_FULL;
                else if (bus.ex_ready)  state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase

        if (load_c) begin
            rs1_val_d = op1_c;
            rs2_val_d = op2_c;
            imm_d     = bus.id_imm;
            pc_d      = bus.id_pc;
            cw_d      = bus.id_cw;
        end
    end

    // Saturating count of cycles a valid instruction is held back by a hazard
    always_comb begin : stall_cnt_p
        stall_cnt_d = stall_cnt_q;
        if (bus.id_valid && hazard_c && !bus.flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : regs_p
        if (rst) begin
            state_q     <= S_EMPTY;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            cw_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            cw_q        <= cw_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.id_ready   = id_ready_c;
    assign bus.ex_valid   = ex_valid_c;
    assign bus.ex_rs1_val = rs1_val_q;
    assign bus.ex_rs2_val = rs2_val_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_pc      = pc_q;
    assign bus.ex_cw      = cw_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Testbench for decode_issue_stage: instance a bypasses (FWD_EN=1, CNT_W=16),
// instance b stalls on every RAW match (FWD_EN=0, CNT_W=4).
module tb_decode_issue_stage;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [27:0] cw;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic        flush;
        logic        ex_ready;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [27:0] cw;
        logic [2:0]  we;
        logic [2:0]  pend;
        logic [14:0] rd;
        logic [95:0] data;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    stim_t [1:0] st;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    decode_issue_stage_if #(.XLEN(32), .NSRC(3), .CW_W(28), .CNT_W(16)) ia ();
    decode_issue_stage_if #(.XLEN(32), .NSRC(3), .CW_W(28), .CNT_W(4))  ib ();

    decode_issue_stage #(.XLEN(32), .NSRC(3), .CW_W(28), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    decode_issue_stage #(.XLEN(32), .NSRC(3), .CW_W(28), .FWD_EN(0), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    always #5 clk = ~clk;

    assign ia.flush      = st[0].flush;
    assign ia.id_valid   = st[0].valid;
    assign ia.id_rs1     = st[0].rs1;
    assign ia.id_rs2     = st[0].rs2;
    assign ia.id_use_rs1 = st[0].u1;
    assign ia.id_use_rs2 = st[0].u2;
    assign ia.id_rs1_val = st[0].v1;
    assign ia.id_rs2_val = st[0].v2;
    assign ia.id_cw      = st[0].cw;
    assign ia.id_imm     = st[0].imm;
    assign ia.id_pc      = st[0].pc;
    assign ia.fwd_we     = st[0].we;
    assign ia.fwd_pend   = st[0].pend;
    assign ia.fwd_rd     = st[0].rd;
    assign ia.fwd_data   = st[0].data;
    assign ia.ex_ready   = st[0].ex_ready;

    assign ib.flush      = st[1].flush;
    assign ib.id_valid   = st[1].valid;
    assign ib.id_rs1     = st[1].rs1;
    assign ib.id_rs2     = st[1].rs2;
    assign ib.id_use_rs1 = st[1].u1;
    assign ib.id_use_rs2 = st[1].u2;
    assign ib.id_rs1_val = st[1].v1;
    assign ib.id_rs2_val = st[1].v2;
    assign ib.id_cw      = st[1].cw;
    assign ib.id_imm     = st[1].imm;
    assign ib.id_pc      = st[1].pc;
    assign ib.fwd_we     = st[1].we;
    assign ib.fwd_pend   = st[1].pend;
    assign ib.fwd_rd     = st[1].rd;
    assign ib.fwd_data   = st[1].data;
    assign ib.ex_ready   = st[1].ex_ready;

    logic [1:0]        o_valid, o_ready;
    logic [1:0][31:0]  o_rs1, o_rs2, o_imm, o_pc;
    logic [1:0][27:0]  o_cw;
    logic [1:0][15:0]  o_cnt;

    assign o_valid = {ib.ex_valid, ia.ex_valid};
    assign o_ready = {ib.id_ready, ia.id_ready};
    assign o_rs1   = {ib.ex_rs1_val, ia.ex_rs1_val};
    assign o_rs2   = {ib.ex_rs2_val, ia.ex_rs2_val};
    assign o_imm   = {ib.ex_imm, ia.ex_imm};
    assign o_pc    = {ib.ex_pc, ia.ex_pc};
    assign o_cw    = {ib.ex_cw, ia.ex_cw};
    assign o_cnt   = {16'(ib.stall_cnt), ia.stall_cnt};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one instruction on DUT `sel`; call at posedge+1. Expected entry is
    // queued at the negedge where the handshake is due to complete.
    task automatic issue(input int sel,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [27:0] cw,
                         input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        int   n;
        bit   done;
        e = '{rs1: e1, rs2: e2, imm: imm, pc: pc, cw: cw};
        st[sel].rs1 = rs1;  st[sel].rs2 = rs2;
        st[sel].u1  = u1;   st[sel].u2  = u2;
        st[sel].v1  = v1;   st[sel].v2  = v2;
        st[sel].imm = imm;  st[sel].pc  = pc;
        st[sel].cw  = cw;
        st[sel].valid = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (o_ready[sel]) begin
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
                done = 1'b1;
            end else if (++n > 50) begin
                check("issue_ready_timeout", 64'(o_ready[sel]), 64'd1);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        st[sel].valid = 1'b0;
    endtask

    // Scoreboard: compare each entry as execute accepts it
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int s = 0; s < 2; s++) begin
            if (!rst && o_valid[s] && st[s].ex_ready) begin
                have = 1'b0;
                e    = '0;
                if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    check("sb_unexpected_valid", 64'(o_valid[s]), 64'd0);
                end else begin
                    check("sb_rs1", 64'(o_rs1[s]), 64'(e.rs1));
                    check("sb_rs2", 64'(o_rs2[s]), 64'(e.rs2));
                    check("sb_imm", 64'(o_imm[s]), 64'(e.imm));
                    check("sb_pc",  64'(o_pc[s]),  64'(e.pc));
                    check("sb_cw",  64'(o_cw[s]),  64'(e.cw));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        st = '0;
        st[0].ex_ready = 1'b1;
        st[1].ex_ready = 1'b1;

        // Reset state, before any clock edge
        #2;
        for (int s = 0; s < 2; s++) begin
            check("rst_valid", 64'(o_valid[s]), 64'd0);
            check("rst_cnt",   64'(o_cnt[s]),   64'd0);
            check("rst_rs1",   64'(o_rs1[s]),   64'd0);
            check("rst_rs2",   64'(o_rs2[s]),   64'd0);
            check("rst_imm",   64'(o_imm[s]),   64'd0);
            check("rst_pc",    64'(o_pc[s]),    64'd0);
            check("rst_cw",    64'(o_cw[s]),    64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Youngest of two matching sources wins
        st[0].we   = 3'b011;
        st[0].pend = 3'b000;
        st[0].rd   = {5'd12, 5'd5, 5'd5};
        st[0].data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        issue(0, 5'd5, 5'd9, 1'b1, 1'b1, 32'h1111, 32'h9999, 32'h100, 32'h4000, 28'h1234567,
              32'h0000_000A, 32'h9999);
        // Older sources selected when younger ones are not writing
        st[0].we = 3'b110;
        issue(0, 5'd5, 5'd12, 1'b1, 1'b1, 32'h2222, 32'h3333, 32'h104, 32'h4004, 28'h0ABCDEF,
              32'h0000_000B, 32'h0000_000C);
        // Unused operand ignores a match
        st[0].we = 3'b111;
        issue(0, 5'd5, 5'd3, 1'b0, 1'b1, 32'h4444, 32'h5555, 32'h108, 32'h4008, 28'h0000001,
              32'h4444, 32'h5555);
        // Address 0 never matches
        st[0].rd = {5'd12, 5'd5, 5'd0};
        issue(0, 5'd0, 5'd5, 1'b1, 1'b1, 32'h6666, 32'h7777, 32'h10C, 32'h400C, 28'h0000002,
              32'h6666, 32'h0000_000B);
        repeat (2) begin @(posedge clk); #1; end

        // Load-use stall on pending youngest source, then bypass once it resolves
        st[0].we   = 3'b001;
        st[0].pend = 3'b001;
        st[0].rd   = {5'd0, 5'd0, 5'd7};
        st[0].data = {32'h0, 32'h0, 32'h0000_D00D};
        st[0].rs1 = 5'd1; st[0].u1 = 1'b1;
        st[0].rs2 = 5'd7; st[0].u2 = 1'b1;
        st[0].valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("haz_ready", 64'(o_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        check("haz_cnt",   64'(o_cnt[0]),   64'd3);
        check("haz_valid", 64'(o_valid[0]), 64'd0);
        st[0].pend = 3'b000;
        issue(0, 5'd1, 5'd7, 1'b1, 1'b1, 32'h8888, 32'h9990, 32'h110, 32'h4010, 28'h0000003,
              32'h8888, 32'h0000_D00D);
        repeat (2) begin @(posedge clk); #1; end
        check("haz_cnt_hold", 64'(o_cnt[0]), 64'd3);

        // Backpressure hold, then back-to-back accept + load
        st[0].we = 3'b000;
        st[0].ex_ready = 1'b0;
        issue(0, 5'd2, 5'd3, 1'b1, 1'b1, 32'hAAAA_0001, 32'hAAAA_0002, 32'h1, 32'h100, 28'h11,
              32'hAAAA_0001, 32'hAAAA_0002);
        st[0].rs1 = 5'd4; st[0].rs2 = 5'd6;
        st[0].v1 = 32'hBBBB_0001; st[0].v2 = 32'hBBBB_0002;
        st[0].imm = 32'h2; st[0].pc = 32'h104; st[0].cw = 28'h22;
        st[0].valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            st[0].data = {32'h0, 32'h0, 32'(k + 32'h0BAD)};
            @(negedge clk);
            check("hold_ready", 64'(o_ready[0]), 64'd0);
            check("hold_valid", 64'(o_valid[0]), 64'd1);
            check("hold_rs1",   64'(o_rs1[0]),   64'hAAAA_0001);
            check("hold_pc",    64'(o_pc[0]),    64'h100);
            @(posedge clk); #1;
        end
        st[0].ex_ready = 1'b1;
        issue(0, 5'd4, 5'd6, 1'b1, 1'b1, 32'hBBBB_0001, 32'hBBBB_0002, 32'h2, 32'h104, 28'h22,
              32'hBBBB_0001, 32'hBBBB_0002);
        @(negedge clk);
        check("b2b_valid", 64'(o_valid[0]), 64'd1);
        @(posedge clk); #1;

        // Flush while full with a pending instruction
        st[0].ex_ready = 1'b0;
        issue(0, 5'd8, 5'd9, 1'b1, 1'b1, 32'hCCCC_0001, 32'hCCCC_0002, 32'h3, 32'h108, 28'h33,
              32'hCCCC_0001, 32'hCCCC_0002);
        st[0].rs1 = 5'd10; st[0].v1 = 32'hDDDD_0001;
        st[0].valid = 1'b1;
        st[0].flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 64'(o_ready[0]), 64'd0);
        @(posedge clk); #1;
        st[0].flush = 1'b0;
        st[0].valid = 1'b0;
        check("flush_valid", 64'(o_valid[0]), 64'd0);
        check("flush_nocap", 64'(o_rs1[0] == 32'hDDDD_0001), 64'd0);
        void'(q0.pop_back());
        @(negedge clk);
        check("flush_valid2", 64'(o_valid[0]), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-transfer
        issue(0, 5'd11, 5'd12, 1'b1, 1'b1, 32'hEEEE_0001, 32'hEEEE_0002, 32'h4, 32'h10C, 28'h44,
              32'hEEEE_0001, 32'hEEEE_0002);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(o_valid[0]), 64'd0);
        check("arst_rs1",   64'(o_rs1[0]),   64'd0);
        check("arst_rs2",   64'(o_rs2[0]),   64'd0);
        check("arst_imm",   64'(o_imm[0]),   64'd0);
        check("arst_pc",    64'(o_pc[0]),    64'd0);
        check("arst_cw",    64'(o_cw[0]),    64'd0);
        check("arst_cnt",   64'(o_cnt[0]),   64'd0);
        void'(q0.pop_back());
        st[0].ex_ready = 1'b1;
        st[0].valid = 1'b1;
        @(posedge clk); #1;
        check("rst_noload", 64'(o_valid[0]), 64'd0);
        st[0].valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(0, 5'd13, 5'd14, 1'b1, 1'b1, 32'hF0F0_0001, 32'hF0F0_0002, 32'h5, 32'h110, 28'h55,
              32'hF0F0_0001, 32'hF0F0_0002);

        // No-bypass instance: any match stalls, counter saturates at 15
        st[1].we   = 3'b100;
        st[1].pend = 3'b000;
        st[1].rd   = {5'd4, 5'd0, 5'd0};
        st[1].data = {32'h0000_0444, 32'h0, 32'h0};
        st[1].rs1 = 5'd4; st[1].u1 = 1'b1;
        st[1].rs2 = 5'd0; st[1].u2 = 1'b0;
        st[1].v1 = 32'h1234;
        st[1].valid = 1'b1;
        @(negedge clk);
        check("nofwd_ready", 64'(o_ready[1]), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("nofwd_sat", 64'(o_cnt[1]), 64'd15);
        check("nofwd_ready2", 64'(o_ready[1]), 64'd0);
        check("nofwd_valid", 64'(o_valid[1]), 64'd0);
        st[1].valid = 1'b0;
        st[1].we = 3'b111;
        st[1].rd = {5'd0, 5'd0, 5'd0};
        issue(1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h5A5A, 32'hA5A5, 32'h6, 32'h200, 28'h66,
              32'h5A5A, 32'hA5A5);
        st[1].rd = {5'd4, 5'd9, 5'd8};
        issue(1, 5'd6, 5'd7, 1'b1, 1'b1, 32'h6060, 32'h7070, 32'h7, 32'h204, 28'h77,
              32'h6060, 32'h7070);
        check("nofwd_sat_hold", 64'(o_cnt[1]), 64'd15);

        repeat (3) begin @(posedge clk); #1; end
        check("sb_drain_a", 64'(q0.size()), 64'd0);
        check("sb_drain_b", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
